// File: rtl/fm_radio_pkg.sv
// Shared FM radio datapath constants and the 16-bit sample quantizer
// used by both the IQ front end and the audio path.
package fm_radio_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int BYTE_SIZE  = 8;
    localparam int QUANT_BITS = 10;

    // Sign-extend to the datapath width first so the shift never loses the sign.
    function automatic logic signed [DATA_SIZE-1:0] quantize(input logic signed [15:0] sample);
        logic signed [DATA_SIZE-1:0] wide;
        wide = DATA_SIZE'(sample);
        return wide <<< QUANT_BITS;
    endfunction

endpackage

// File: rtl/iq_byte_unpacker.sv
// Pops usrp.dat bytes, assembles I-low/I-high/Q-low/Q-high groups and pushes
// one quantized I/Q pair into the I and Q sample FIFOs together.
//
// state   | meaning
// S_READ  | popping bytes of the current group into byte slots
// S_WRITE | quantized pair registered, waiting for both FIFOs to have room
module iq_byte_unpacker
    import fm_radio_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [BYTE_SIZE-1:0] in_dout,
    input  logic                 i_out_full,
    output logic                 i_out_wr_en,
    output logic [DATA_SIZE-1:0] i_out_din,
    input  logic                 q_out_full,
    output logic                 q_out_wr_en,
    output logic [DATA_SIZE-1:0] q_out_din
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                        state_q;
    logic [1:0]                    byte_cnt_q;
    logic [2:0][BYTE_SIZE-1:0]     bytes_q;
    logic                          run_q;
    logic [DATA_SIZE-1:0]          i_din_q;
    logic [DATA_SIZE-1:0]          q_din_q;
    logic                          pair_ready;

    assign pair_ready = !i_out_full && !q_out_full;

    // run_q keeps every enable low for the first cycle after reset release.
    assign in_rd_en    = run_q && (state_q == S_READ) && !in_empty;
    assign i_out_wr_en = (state_q == S_WRITE) && pair_ready;
    assign q_out_wr_en = (state_q == S_WRITE) && pair_ready;
    assign i_out_din   = i_din_q;
    assign q_out_din   = q_din_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_READ;
            byte_cnt_q <= 2'd0;
            bytes_q    <= '0;
            run_q      <= 1'b0;
            i_din_q    <= '0;
            q_din_q    <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_READ: begin
                    if (in_rd_en) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // The Q high byte is used straight off the FIFO head.
                        if (byte_cnt_q == 2'd3) begin
                            i_din_q <= quantize({bytes_q[1], bytes_q[0]});
                            q_din_q <= quantize({in_dout, bytes_q[2]});
                            state_q <= S_WRITE;
                        end else begin
                            bytes_q[byte_cnt_q] <= in_dout;
                        end
                    end
                end
                S_WRITE: begin
                    if (pair_ready) begin
                        state_q <= S_READ;
                    end
                end
                default: state_q <= S_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_byte_unpacker.sv
// Self-checking bench for iq_byte_unpacker: byte FIFO and sample FIFOs are
// emulated here, expected pairs come from a queue-based group model.
module tb_iq_byte_unpacker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [7:0]  in_dout = 8'h00;
    logic        i_out_full = 1'b0;
    logic        i_out_wr_en;
    logic [31:0] i_out_din;
    logic        q_out_full = 1'b0;
    logic        q_out_wr_en;
    logic [31:0] q_out_din;

    iq_byte_unpacker dut (
        .clock       (clock),
        .reset       (reset),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .in_dout     (in_dout),
        .i_out_full  (i_out_full),
        .i_out_wr_en (i_out_wr_en),
        .i_out_din   (i_out_din),
        .q_out_full  (q_out_full),
        .q_out_wr_en (q_out_wr_en),
        .q_out_din   (q_out_din)
    );

    always #5 clock = ~clock;

    logic [7:0]  byteq[$];
    logic [7:0]  grp[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          nwrites = 0;
    logic [31:0] last_i = '0, last_q = '0;
    logic [31:0] prev_i = '0, prev_q = '0;
    logic        prev_rd = 1'b0;
    logic        prev_valid = 1'b0;

    // Reference: a completed 4-byte group becomes two signed 16-bit values times 2^10.
    function automatic void model_byte(input logic [7:0] b);
        int signed iv, qv;
        grp.push_back(b);
        if (grp.size() == 4) begin
            iv = int'($signed({grp[1], grp[0]}));
            qv = int'($signed({grp[3], grp[2]}));
            exp_i.push_back(32'(iv * 1024));
            exp_q.push_back(32'(qv * 1024));
            grp.delete();
        end
    endfunction

    task automatic cycle(input logic gap, input logic ifull, input logic qfull,
                         output logic rd, output logic wr);
        logic [31:0] ei, eq;
        @(negedge clock);
        in_empty   = gap || (byteq.size() == 0);
        in_dout    = (byteq.size() != 0) ? byteq[0] : 8'($urandom);
        i_out_full = ifull;
        q_out_full = qfull;
        #1;
        rd = in_rd_en;
        wr = i_out_wr_en;
        vectors++;
        if (in_rd_en === 1'b1 && in_empty)
            begin miscompares++; $display("FAIL pop_when_empty: in_rd_en=%b in_empty=%b", in_rd_en, in_empty); end
        vectors++;
        if (i_out_wr_en !== q_out_wr_en)
            begin miscompares++; $display("FAIL wr_pair: i_wr=%b q_wr=%b required equal", i_out_wr_en, q_out_wr_en); end
        vectors++;
        if (in_rd_en === 1'b1 && i_out_wr_en === 1'b1)
            begin miscompares++; $display("FAIL pop_push_overlap: rd=%b wr=%b", in_rd_en, i_out_wr_en); end
        vectors++;
        if (i_out_wr_en === 1'b1 && (ifull || qfull))
            begin miscompares++; $display("FAIL wr_into_full: wr=1 i_full=%b q_full=%b", ifull, qfull); end
        if (prev_valid && !prev_rd) begin
            vectors++;
            if (i_out_din !== prev_i || q_out_din !== prev_q) begin
                miscompares++;
                $display("FAIL data_stable: i=%h q=%h required i=%h q=%h", i_out_din, q_out_din, prev_i, prev_q);
            end
        end
        if (i_out_wr_en === 1'b1) begin
            vectors++;
            if (exp_i.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: i=%h q=%h with no pair expected", i_out_din, q_out_din);
            end else begin
                ei = exp_i.pop_front();
                eq = exp_q.pop_front();
                if (i_out_din !== ei || q_out_din !== eq) begin
                    miscompares++;
                    $display("FAIL write_data: i=%h q=%h required i=%h q=%h", i_out_din, q_out_din, ei, eq);
                end
            end
            nwrites++;
            last_i = i_out_din;
            last_q = q_out_din;
        end
        if (in_rd_en === 1'b1 && !in_empty) model_byte(byteq.pop_front());
        prev_valid = 1'b1;
        prev_rd    = in_rd_en;
        prev_i     = i_out_din;
        prev_q     = q_out_din;
    endtask

    task automatic flush();
        logic rd, wr;
        int   n = 0;
        while ((byteq.size() != 0 || exp_i.size() != 0) && n < 200) begin
            cycle(1'b0, 1'b0, 1'b0, rd, wr);
            n++;
        end
        vectors++;
        if (byteq.size() != 0 || exp_i.size() != 0 || grp.size() != 0) begin
            miscompares++;
            $display("FAIL flush_timeout: bytes_left=%0d pairs_left=%0d partial=%0d required 0",
                     byteq.size(), exp_i.size(), grp.size());
        end
    endtask

    // Feeds one group plus optional extra groups, then checks per-cycle enables against masks.
    task automatic run_pattern(input string name, input logic [31:0] bytes4, input int extra,
                               input int ncyc, input logic [15:0] gap_m, input logic [15:0] qfull_m,
                               input logic [15:0] rd_m, input logic [15:0] wr_m,
                               input logic [31:0] ei, input logic [31:0] eq);
        logic rd, wr;
        int   w0;
        for (int k = 0; k < 4; k++) byteq.push_back(bytes4[8*k +: 8]);
        for (int k = 0; k < extra; k++) byteq.push_back(8'($urandom));
        w0 = nwrites;
        for (int c = 0; c < ncyc; c++) begin
            cycle(gap_m[c], 1'b0, qfull_m[c], rd, wr);
            vectors++;
            if (rd !== rd_m[c] || wr !== wr_m[c]) begin
                miscompares++;
                $display("FAIL %s_enables cycle %0d: rd=%b wr=%b required rd=%b wr=%b", name, c, rd, wr, rd_m[c], wr_m[c]);
            end
        end
        vectors++;
        if (nwrites - w0 != 1 || last_i !== ei || last_q !== eq) begin
            miscompares++;
            $display("FAIL %s_value: writes=%0d i=%h q=%h required writes=1 i=%h q=%h",
                     name, nwrites - w0, last_i, last_q, ei, eq);
        end
        flush();
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (in_rd_en !== 1'b0 || i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0 ||
            i_out_din !== 32'h0 || q_out_din !== 32'h0) begin
            miscompares++;
            $display("FAIL %s: rd=%b iwr=%b qwr=%b i=%h q=%h required all 0",
                     name, in_rd_en, i_out_wr_en, q_out_wr_en, i_out_din, q_out_din);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_empty = 1'b0; in_dout = 8'hAA;
        repeat (3) @(negedge clock);
        #1 check_zero("reset_outputs");
        @(negedge clock);
        reset = 1'b1;
        #1 check_zero("first_cycle_after_release");
        prev_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_pattern("basic", 32'hFFFE1234, 0, 6, 16'h0000, 16'h0000, 16'h000F, 16'h0010,
                    32'h0048D000, 32'hFFFFF800);
    endtask

    task automatic test_sign_boundary();
        run_pattern("sign", 32'h7FFF8000, 0, 6, 16'h0000, 16'h0000, 16'h000F, 16'h0010,
                    32'hFE000000, 32'h01FFFC00);
    endtask

    task automatic test_empty_gaps();
        run_pattern("gaps", 32'hFFFE1234, 0, 8, 16'h0026, 16'h0000, 16'h0059, 16'h0080,
                    32'h0048D000, 32'hFFFFF800);
    endtask

    task automatic test_back_pressure();
        run_pattern("backpressure", 32'h7FFF8000, 4, 13, 16'h0000, 16'h07F0, 16'h100F, 16'h0800,
                    32'hFE000000, 32'h01FFFC00);
    endtask

    task automatic test_reset_mid_group();
        logic rd, wr;
        byteq.push_back(8'h11);
        byteq.push_back(8'h22);
        cycle(1'b0, 1'b0, 1'b0, rd, wr);
        cycle(1'b0, 1'b0, 1'b0, rd, wr);
        @(negedge clock);
        reset = 1'b0;
        byteq.delete();
        grp.delete();
        in_empty = 1'b0;
        #1 check_zero("mid_reset_outputs");
        repeat (2) @(negedge clock);
        #1 check_zero("mid_reset_held");
        @(negedge clock);
        reset = 1'b1;
        #1 check_zero("mid_reset_release");
        prev_valid = 1'b0;
        run_pattern("after_reset", 32'h01005678, 0, 6, 16'h0000, 16'h0000, 16'h000F, 16'h0010,
                    32'h0159E000, 32'h00040000);
    endtask

    task automatic test_random_stream();
        logic rd, wr;
        int   w0, n;
        w0 = nwrites;
        for (int k = 0; k < 4000; k++) byteq.push_back(8'($urandom));
        n = 0;
        while ((nwrites - w0) < 1000 && n < 40000) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, rd, wr);
            n++;
        end
        vectors++;
        if (nwrites - w0 != 1000 || byteq.size() != 0) begin
            miscompares++;
            $display("FAIL random_stream: writes=%0d bytes_left=%0d required writes=1000 bytes_left=0",
                     nwrites - w0, byteq.size());
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_boundary();
        test_empty_gaps();
        test_back_pressure();
        test_reset_mid_group();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iq_byte_unpacker.md
# iq_byte_unpacker

Front-end reader of the FM radio datapath: pops raw `usrp.dat` bytes from the input byte FIFO. The testbench or host fills that FIFO through `in_wr_en`/`in_full`/`in_din`. The block assembles each 4-byte group into one signed I sample and one signed Q sample, quantizes both to fixed point, and pushes them as a pair into the I and Q sample FIFOs that feed the channel FIR. It is the consumer end of the byte-stream interface the bench drives.

## Interface
- `DATA_SIZE`, 32, width of quantized I/Q output words
- `BYTE_SIZE`, 8, width of input FIFO words
- `QUANT_BITS`, 10, left-shift applied when quantizing a 16-bit sample
- `clock`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low
- `in_empty`  in  1  byte FIFO empty flag
- `in_rd_en`  out  1  pop byte FIFO
- `in_dout`  in  BYTE_SIZE  byte FIFO head; first-word fall-through, valid whenever `!in_empty`
- `i_out_full`  in  1  I FIFO full
- `i_out_wr_en`  out  1  push I FIFO
- `i_out_din`  out  DATA_SIZE  quantized signed I sample
- `q_out_full`  in  1  Q FIFO full
- `q_out_wr_en`  out  1  push Q FIFO
- `q_out_din`  out  DATA_SIZE  quantized signed Q sample

## Operation
- Byte order per sample group: b0 = I low, b1 = I high, b2 = Q low, b3 = Q high (little-endian 16-bit, I first).
- FSM has two states: S_READ and S_WRITE.
- S_READ:
  - `in_rd_en = !in_empty` (combinational).
  - On each pop, store `in_dout` into byte slot `byte_cnt` and increment the 2-bit `byte_cnt`.
  - The pop with `byte_cnt == 3` registers the quantized I/Q into `i_out_din`/`q_out_din`, wraps `byte_cnt` to 0, and moves to S_WRITE.
- S_WRITE:
  - `in_rd_en = 0`.
  - When `!i_out_full && !q_out_full`, assert both `i_out_wr_en` and `q_out_wr_en` (combinational, same cycle) and return to S_READ.
  - Otherwise hold. Never write one FIFO without the other.
- Arithmetic:
  - i16 = signed {b1,b0} and q16 = signed {b3,b2}.
  - Sign-extend each to DATA_SIZE, then shift left by QUANT_BITS. No saturation; 16 + QUANT_BITS ≤ DATA_SIZE is guaranteed by parameters.
- Empty mid-group: stall in S_READ with partial bytes retained; resume on the next non-empty cycle.
- Reset asserted at any time:
  - Partial group discarded.
  - State = S_READ, `byte_cnt = 0`, held bytes = 0.
  - `i_out_din = q_out_din = 0`.
  - `in_rd_en = i_out_wr_en = q_out_wr_en = 0`.
  - No pending write survives reset.

## Timing
- All outputs are 0 while `reset` is low and in the first cycle after release. Enables are combinational from state/flags, so they are 0 in reset.
- Minimum per-pair cost is 5 cycles: 4 pop cycles plus 1 write cycle. With continuous input, the write occurs the cycle after the 4th pop.
- `i_out_din`/`q_out_din` are stable from the cycle after the 4th pop until the write cycle completes; they change only on a 4th pop.
- A full flag that deasserts in cycle N makes the write happen in cycle N. Back-pressure adds exactly the stall cycles.
- No simultaneous pop and push ever occur; the states are exclusive.

## Structure
- Shared `fm_radio_pkg`:
  - constants `DATA_SIZE`, `BYTE_SIZE`, `QUANT_BITS`
  - function `quantize(input signed [15:0]) -> signed [DATA_SIZE-1:0]`, reused by the audio path
- FSM state enum is local to the module.
- No sub-module; FIFOs are instantiated by `fm_radio_top`.
- Target size is roughly 120–160 lines of RTL.

## Test plan
- Bytes 34,12,FE,FF with FIFOs never full: one write of `i_out_din` = 0x0048D000 and `q_out_din` = 0xFFFFF800; write cycle immediately follows the 4th pop.
- Bytes 00,80,FF,7F: I = 0xFE000000 (-32768<<10), Q = 0x01FFFC00; confirms the sign boundaries.
- Insert empty gaps after bytes 1 and 3: same values as the first case; `in_rd_en` is low during the gaps and no byte is duplicated or lost.
- Hold `q_out_full` high for 7 cycles at write time: no `in_rd_en`, no `i_out_wr_en`; both write enables rise together in the cycle `q_out_full` falls.
- Assert reset after 2 bytes, release, then feed 4 new bytes: the output reflects only the new bytes; all outputs read 0 during reset.
- Stream the first 32000 bytes of `usrp.dat`: exactly 8000 I/Q writes, matching the golden C `read_IQ` quantized values.
